// File: rtl/cft_bus_pkg.sv
// Shared types and default widths for the address-register bus sequencer family.
package cft_bus_pkg;

  localparam int unsigned DefIbusW = 16;
  localparam int unsigned DefExtW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  typedef enum logic {
    CycMem,
    CycIo
  } cyc_e;

endpackage

// File: rtl/reg_ar_seq_if.sv
// Bus bundle between control unit / front panel (master) and reg_ar_seq (slave).
interface reg_ar_seq_if #(
  parameter int unsigned IBUS_W  = cft_bus_pkg::DefIbusW,
  parameter int unsigned EXT_W   = cft_bus_pkg::DefExtW,
  parameter int unsigned NDEV    = 4,
  parameter int unsigned FPSEL_W = 2
) ();

  localparam int unsigned ADDR_W = IBUS_W + EXT_W;

  logic [IBUS_W-1:0]  ibus;
  logic [EXT_W-1:0]   aext;
  logic               nwrite_ar;
  logic               inc_ar;
  logic               req_mem;
  logic               req_io;
  logic [ADDR_W-1:0]  ab;
  logic               ab_oe;
  logic               nmem;
  logic               nio;
  logic [NDEV-1:0]    niodev;
  logic               busy;
  logic               done;
  logic               err;
  logic               nfparh;
  logic [FPSEL_W-1:0] fp_sel;
  logic [7:0]         fpd;
  logic               fpd_oe;

  modport master (
    output ibus, aext, nwrite_ar, inc_ar, req_mem, req_io, nfparh, fp_sel,
    input  ab, ab_oe, nmem, nio, niodev, busy, done, err, fpd, fpd_oe
  );

  modport slave (
    input  ibus, aext, nwrite_ar, inc_ar, req_mem, req_io, nfparh, fp_sel,
    output ab, ab_oe, nmem, nio, niodev, busy, done, err, fpd, fpd_oe
  );

endinterface

// File: rtl/io_page_decode.sv
// Registered I/O page decoder: page number to active-low one-hot device strobes.
module io_page_decode #(
  parameter int unsigned PageW  = 16,
  parameter int unsigned NumDev = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [PageW-1:0]  page_i,
  output logic [NumDev-1:0] niodev_o
);

  logic [NumDev-1:0] niodev_d, niodev_q;

  // Full-width compare so any high page bit set leaves every strobe inactive.
  always_comb begin
    niodev_d = '1;
    for (int i = 0; i < NumDev; i++) begin
      if (en_i && (page_i == PageW'(i))) begin
        niodev_d[i] = 1'b0;
      end
    end
  end

  // Strobe register, all inactive in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      niodev_q <= '1;
    end else begin
      niodev_q <= niodev_d;
    end
  end

  assign niodev_o = niodev_q;

endmodule

// File: rtl/reg_ar_seq.sv
// Wide address register with load/increment, SETUP/STROBE/HOLD bus-cycle sequencer,
// I/O page strobes and a front-panel byte readout.
module reg_ar_seq
  import cft_bus_pkg::*;
#(
  parameter int unsigned IBUS_W      = DefIbusW,
  parameter int unsigned EXT_W       = DefExtW,
  parameter int unsigned IO_PAGE_LSB = 8,
  parameter int unsigned NDEV        = 4,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned FPSEL_W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  reg_ar_seq_if.slave  bus
);

  localparam int unsigned ADDR_W = IBUS_W + EXT_W;
  localparam int unsigned PageW  = ADDR_W - IO_PAGE_LSB;
  localparam int unsigned CntMax = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned PadW   = 8 << FPSEL_W;

  state_e            state_d, state_q;
  cyc_e              cyc_d, cyc_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic [ADDR_W-1:0] ar_d, ar_q;
  logic [ADDR_W-1:0] ab_d, ab_q;
  logic              ab_oe_d, ab_oe_q;
  logic              nmem_d, nmem_q;
  logic              nio_d, nio_q;
  logic              done_d, done_q;
  logic              err_d, err_q;
  logic [7:0]        fpd_d, fpd_q;
  logic              fpd_oe_d, fpd_oe_q;
  logic [PadW-1:0]   ar_pad;
  logic              dev_en;

  // Sequencer next state, AR update and registered-strobe precompute.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    ar_d    = ar_q;
    ab_d    = ab_q;
    ab_oe_d = ab_oe_q;
    done_d  = 1'b0;
    // AR writes are only legal in IDLE; flag them everywhere else.
    err_d   = (state_q != StIdle) && (!bus.nwrite_ar || bus.inc_ar);

    unique case (state_q)
      StIdle: begin
        ab_d    = '0;
        ab_oe_d = 1'b0;
        if (!bus.nwrite_ar) begin
          ar_d = {bus.aext, bus.ibus};
        end else if (bus.inc_ar) begin
          ar_d = ar_q + ADDR_W'(1);
        end
        if (bus.req_mem && bus.req_io) begin
          err_d = 1'b1;
        end else if (bus.req_mem || bus.req_io) begin
          state_d = StSetup;
          cnt_d   = '0;
          cyc_d   = bus.req_io ? CycIo : CycMem;
          ab_d    = ar_q;
          ab_oe_d = 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SETUP_CYC - 1)) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == CntW'(STROBE_CYC - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        state_d = StIdle;
        done_d  = 1'b1;
        ab_d    = '0;
        ab_oe_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so the flops change cleanly on the edge.
    nmem_d = !((state_d == StStrobe) && (cyc_d == CycMem));
    nio_d  = !((state_d == StStrobe) && (cyc_d == CycIo));
    dev_en = (state_d == StStrobe) && (cyc_d == CycIo);
  end

  // Front-panel byte lane select; lanes past ADDR_W read as zero.
  always_comb begin
    ar_pad   = PadW'(ar_q);
    fpd_d    = ar_pad[{bus.fp_sel, 3'b000} +: 8];
    fpd_oe_d = !bus.nfparh;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cyc_q    <= CycMem;
      cnt_q    <= '0;
      ar_q     <= '0;
      ab_q     <= '0;
      ab_oe_q  <= 1'b0;
      nmem_q   <= 1'b1;
      nio_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fpd_q    <= '0;
      fpd_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      ar_q     <= ar_d;
      ab_q     <= ab_d;
      ab_oe_q  <= ab_oe_d;
      nmem_q   <= nmem_d;
      nio_q    <= nio_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fpd_q    <= fpd_d;
      fpd_oe_q <= fpd_oe_d;
    end
  end

  io_page_decode #(
    .PageW  (PageW),
    .NumDev (NDEV)
  ) u_io_page_decode (
    .clk      (clk),
    .reset    (reset),
    .en_i     (dev_en),
    .page_i   (ab_d[ADDR_W-1:IO_PAGE_LSB]),
    .niodev_o (bus.niodev)
  );

  assign bus.ab     = ab_q;
  assign bus.ab_oe  = ab_oe_q;
  assign bus.nmem   = nmem_q;
  assign bus.nio    = nio_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.fpd    = fpd_q;
  assign bus.fpd_oe = fpd_oe_q;

endmodule

// File: tb/tb_reg_ar_seq.sv
// Directed plus randomized bench for reg_ar_seq against a cycle-schedule reference model.
module tb_reg_ar_seq;

  localparam int unsigned IbusW     = 16;
  localparam int unsigned ExtW      = 8;
  localparam int unsigned IoLsb     = 8;
  localparam int unsigned NDev      = 4;
  localparam int unsigned SetupCyc  = 1;
  localparam int unsigned StrobeCyc = 2;
  localparam int unsigned FpselW    = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          checks   = 0;
  int          failures = 0;
  logic [23:0] ar_m;

  reg_ar_seq_if #(
    .IBUS_W  (IbusW),
    .EXT_W   (ExtW),
    .NDEV    (NDev),
    .FPSEL_W (FpselW)
  ) bus ();

  reg_ar_seq #(
    .IBUS_W      (IbusW),
    .EXT_W       (ExtW),
    .IO_PAGE_LSB (IoLsb),
    .NDEV        (NDev),
    .SETUP_CYC   (SetupCyc),
    .STROBE_CYC  (StrobeCyc),
    .FPSEL_W     (FpselW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ar(input string tag);
    chk(tag, 32'(dut.ar_q), 32'(ar_m));
  endtask

  task automatic load(input logic [23:0] v);
    bus.ibus      = v[15:0];
    bus.aext      = v[23:16];
    bus.nwrite_ar = 1'b0;
    tick();
    bus.nwrite_ar = 1'b1;
    ar_m = v;
    chk_ar("load_ar");
  endtask

  // One full bus cycle from the current AR; optionally pulse inc_ar at step poke (busy).
  task automatic bus_cycle(input bit io, input int poke);
    logic [23:0] a;
    int          n;
    int          page;
    bit          strb;
    logic [3:0]  nd;
    a    = ar_m;
    n    = SetupCyc + StrobeCyc + 1;
    page = int'(a >> IoLsb);
    bus.req_io  = io;
    bus.req_mem = !io;
    tick();
    bus.req_io  = 1'b0;
    bus.req_mem = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      strb = (k > SetupCyc) && (k <= SetupCyc + StrobeCyc);
      nd   = 4'hF;
      if (io && strb && page < NDev) nd[page] = 1'b0;
      chk("ab_oe", 32'(bus.ab_oe), 32'(k <= n));
      chk("ab", 32'(bus.ab), (k <= n) ? 32'(a) : 32'd0);
      chk("nmem", 32'(bus.nmem), 32'(!(strb && !io)));
      chk("nio", 32'(bus.nio), 32'(!(strb && io)));
      chk("niodev", 32'(bus.niodev), 32'(nd));
      chk("busy", 32'(bus.busy), 32'(k <= n));
      chk("done", 32'(bus.done), 32'(k == n + 1));
      chk("err_busy", 32'(bus.err), 32'(poke > 0 && k == poke + 1));
      if (k == poke) bus.inc_ar = 1'b1;
      if (k <= n) tick();
      bus.inc_ar = 1'b0;
    end
    chk_ar("ar_after_cycle");
  endtask

  task automatic fp(input logic [1:0] sel, input logic nf);
    logic [7:0] exp_b;
    bus.fp_sel = sel;
    bus.nfparh = nf;
    tick();
    exp_b = (sel == 2'd3) ? 8'h00 : 8'((ar_m >> (8 * int'(sel))) & 24'hFF);
    chk("fpd", 32'(bus.fpd), 32'(exp_b));
    chk("fpd_oe", 32'(bus.fpd_oe), 32'(!nf));
    bus.nfparh = 1'b1;
  endtask

  initial begin
    logic [23:0] rv;
    int          op;
    bus.ibus      = '0;
    bus.aext      = '0;
    bus.nwrite_ar = 1'b1;
    bus.inc_ar    = 1'b0;
    bus.req_mem   = 1'b0;
    bus.req_io    = 1'b0;
    bus.nfparh    = 1'b1;
    bus.fp_sel    = '0;
    ar_m          = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk("rst_ab", 32'(bus.ab), 32'd0);
    chk("rst_ab_oe", 32'(bus.ab_oe), 32'd0);
    chk("rst_nmem", 32'(bus.nmem), 32'd1);
    chk("rst_nio", 32'(bus.nio), 32'd1);
    chk("rst_niodev", 32'(bus.niodev), 32'hF);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_fpd", 32'(bus.fpd), 32'd0);
    chk("rst_fpd_oe", 32'(bus.fpd_oe), 32'd0);
    chk_ar("rst_ar");

    // Reset during STROBE of an I/O cycle to page 1
    load(24'h000100);
    bus.req_io = 1'b1;
    tick();
    bus.req_io = 1'b0;
    tick();
    chk("mid_nio", 32'(bus.nio), 32'd0);
    chk("mid_niodev", 32'(bus.niodev), 32'hD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ar_m = '0;
    chk("abort_nio", 32'(bus.nio), 32'd1);
    chk("abort_niodev", 32'(bus.niodev), 32'hF);
    chk("abort_ab_oe", 32'(bus.ab_oe), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk_ar("abort_ar");

    // Directed bus cycles
    load(24'h000123);
    bus_cycle(1'b1, 0);
    load(24'h031C6F);
    bus_cycle(1'b0, 0);
    load(24'h000523);
    bus_cycle(1'b1, 0);

    // Increment wrap, load priority, write while busy
    load(24'hFFFFFF);
    bus.inc_ar = 1'b1;
    tick();
    bus.inc_ar = 1'b0;
    ar_m = ar_m + 24'd1;
    chk_ar("inc_wrap");
    bus.ibus      = 16'h0010;
    bus.aext      = 8'h00;
    bus.nwrite_ar = 1'b0;
    bus.inc_ar    = 1'b1;
    tick();
    bus.nwrite_ar = 1'b1;
    bus.inc_ar    = 1'b0;
    ar_m = 24'h000010;
    chk_ar("load_beats_inc");
    bus_cycle(1'b0, 2);

    // Both requests at once
    bus.req_mem = 1'b1;
    bus.req_io  = 1'b1;
    tick();
    bus.req_mem = 1'b0;
    bus.req_io  = 1'b0;
    chk("both_err", 32'(bus.err), 32'd1);
    chk("both_busy", 32'(bus.busy), 32'd0);
    chk("both_ab_oe", 32'(bus.ab_oe), 32'd0);
    tick();
    chk("both_err_clr", 32'(bus.err), 32'd0);
    chk("both_nmem", 32'(bus.nmem), 32'd1);
    chk("both_nio", 32'(bus.nio), 32'd1);
    chk("both_busy2", 32'(bus.busy), 32'd0);

    // Front panel
    load(24'hA5B6C7);
    fp(2'd2, 1'b0);
    fp(2'd0, 1'b0);
    fp(2'd1, 1'b1);
    fp(2'd3, 1'b0);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      rv = 24'($urandom);
      if ($urandom_range(0, 1) == 0) rv[23:16] = 8'h00;
      rv[15:8] = 8'($urandom_range(0, 5));
      unique case (op)
        0: load(rv);
        1: begin
          bus.inc_ar = 1'b1;
          tick();
          bus.inc_ar = 1'b0;
          ar_m = ar_m + 24'd1;
          chk_ar("rand_inc");
        end
        2: begin
          load(rv);
          bus_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end
        default: fp(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_ar_seq.md
Name: reg_ar_seq

Overview:
- Clocked, parametrised successor to the address register.
- Holds a wide address (IBUS_W bus bits plus EXT_W extension bits), with load and auto-increment.
- Sequences a complete memory or I/O bus cycle: SETUP, STROBE, HOLD.
- Decodes I/O pages into NDEV device strobes and presents any address byte to the front panel. Sits between the microcode control unit, the external address bus and the front panel.

Parameters:
- IBUS_W, 16, width of internal bus contribution (low address bits)
- EXT_W, 8, width of address extension (high address bits); ADDR_W = IBUS_W+EXT_W
- IO_PAGE_LSB, 8, lowest address bit of the I/O page number
- NDEV, 4, number of I/O page strobes (pages 0..NDEV-1)
- SETUP_CYC, 1, cycles address is driven before strobe (>=1)
- STROBE_CYC, 2, cycles nmem/nio held low (>=1)
- FPSEL_W, 2, width of front-panel byte select (must cover ceil(ADDR_W/8) lanes)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ibus  in  IBUS_W  low address source
- aext  in  EXT_W  high address source
- nwrite_ar  in  1  active-low load strobe, sampled at clk
- inc_ar  in  1  increment AR by one
- req_mem  in  1  start memory cycle (sampled in IDLE only)
- req_io  in  1  start I/O cycle (sampled in IDLE only)
- ab  out  ADDR_W  address bus value (valid when ab_oe=1, else 0)
- ab_oe  out  1  address bus drive enable
- nmem  out  1  active-low memory strobe
- nio  out  1  active-low I/O strobe
- niodev  out  NDEV  active-low I/O page strobes
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle pulse on return to IDLE
- err  out  1  one-cycle pulse on illegal request
- nfparh  in  1  active-low front-panel read request
- fp_sel  in  FPSEL_W  byte lane of AR to show
- fpd  out  8  front-panel data
- fpd_oe  out  1  fpd drive enable

Behaviour:
- Reset values: ar=0, state IDLE, ab=0, ab_oe=0, nmem=1, nio=1, niodev all 1, busy=0, done=0, err=0, fpd=0, fpd_oe=0. Reset mid-cycle aborts immediately; all strobes high the following cycle.
- AR update (IDLE only): nwrite_ar=0 loads ar<={aext,ibus}. Otherwise inc_ar=1 gives ar<=ar+1 modulo 2^ADDR_W (all-ones wraps to 0). Load beats increment when both are asserted.
- Load or inc while busy: ignored; err pulses one cycle; ar unchanged.
- Sequencer states: IDLE, SETUP, STROBE, HOLD.
- IDLE: req_mem xor req_io snapshots ar into ab, latches type, then goes to SETUP; ab_oe=1 from the next cycle. Both requests together: no cycle, err pulses. Requests are ignored in all other states.
- SETUP: lasts SETUP_CYC cycles; ab_oe=1; strobes high.
- STROBE: lasts STROBE_CYC cycles. nmem=0 for a memory cycle, nio=0 for an I/O cycle.
- I/O page decode, during an I/O STROBE only: page = ab[ADDR_W-1:IO_PAGE_LSB]. niodev[page]=0 if page<NDEV; any higher bit set means no niodev asserted. niodev never asserts for memory cycles. At most one niodev bit is low at any time.
- HOLD: one cycle; strobes high, ab_oe=1, ab stable. Next state IDLE with done=1 for one cycle and ab_oe=0.
- Total cycle length: SETUP_CYC+STROBE_CYC+1 cycles from request to done.
- ab, nmem, nio and niodev are all registered outputs with no decode glitches; this removes the '138 spurious-strobe issue.
- Front panel: one-cycle latency. fpd_oe<=~nfparh. fpd<=ar[8*fp_sel +: 8]; bits beyond ADDR_W read 0. Works in any state and is independent of the sequencer.

Decomposition:
- Shared package (cft_bus_pkg): state enum {IDLE,SETUP,STROBE,HOLD}, cycle-type enum {CYC_MEM,CYC_IO}, default widths IBUS_W/EXT_W.
- One sub-module, io_page_decode (registered page-to-one-hot, active-low, NDEV outputs, enable input), reused by future I/O expanders.
- Sequencer and AR stay in the top.

Test Plan:
- Reset during STROBE of an I/O cycle to page 1 -> next cycle nio=1, niodev=4'b1111, ab_oe=0, busy=0, ar=0.
- Load ibus=16'h0123, aext=8'h00, then req_io -> after 1 SETUP cycle: nio=0 and niodev=4'b1101 for 2 cycles, ab=24'h000123; done pulses 4 cycles after request.
- Load aext=8'h03, ibus=16'h1C6F, req_mem -> nmem=0 for 2 cycles, ab=24'h031C6F, niodev stays 4'b1111. I/O to ab=24'h000523 -> nio=0, niodev=4'b1111.
- Load 24'hFFFFFF then inc_ar -> ar=0. nwrite_ar=0 with inc_ar=1 and ibus=16'h0010 -> ar=24'h000010. inc_ar while busy -> err pulse, ar unchanged.
- req_mem and req_io in the same cycle -> err=1 for one cycle, no strobe, busy=0.
- ar=24'hA5B6C7, nfparh=0, fp_sel=2 -> next cycle fpd=8'hA5, fpd_oe=1. fp_sel=0 -> fpd=8'hC7. nfparh=1 -> fpd_oe=0.
